// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: instruction-memory word write bus driven by the UART boot loader.
interface uart_imem_loader_if #(parameter int ADDR_WIDTH = 16);
  logic                  imem_wr;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  modport master (output imem_wr, imem_addr, imem_wdata);
  modport slave  (input  imem_wr, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: 8N1 UART receiver packing little-endian words into imem; optional checksum via UART_LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int BAUD_DIV   = 868,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load_imem,
  input  logic uart_rxd,
  uart_imem_loader_if.master bus,
  output logic loading,
  output logic frame_err
`ifdef UART_LOADER_CHECKSUM_EN
  , output logic [7:0] checksum
`endif
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
  state_t                state;
  logic                  rx_meta, rx_sync, load_q;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [1:0]            idx;
  logic [7:0]            shreg;
  logic [31:0]           word;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  assign loading = load_imem & (state != S_IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      load_q         <= 1'b0;
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      idx            <= '0;
      shreg          <= '0;
      word           <= '0;
      addr_cnt       <= '0;
      frame_err      <= 1'b0;
      bus.imem_wr    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      rx_meta     <= uart_rxd;
      rx_sync     <= rx_meta;
      load_q      <= load_imem;
      bus.imem_wr <= 1'b0;
      if (!load_imem) begin
        // abort takes priority over any byte completing in this cycle
        state    <= S_IDLE;
        idx      <= '0;
        addr_cnt <= '0;
      end else begin
        if (!load_q) begin
          frame_err <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
          checksum  <= '0;
`endif
        end
        case (state)
          S_IDLE:
            if (!rx_sync) begin
              state <= S_START;
              cnt   <= HALF;
            end
          S_START:
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (rx_sync) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              cnt     <= FULL;
              bit_idx <= '0;
            end
          S_DATA:
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              shreg   <= {rx_sync, shreg[7:1]};
              cnt     <= FULL;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= S_STOP;
            end
          S_STOP:
            if (cnt != '0) cnt <= cnt - 1'b1;
            else if (rx_sync) begin
              state         <= S_IDLE;
              word[8*idx +: 8] <= shreg;
              idx           <= idx + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
              checksum      <= checksum + shreg;
`endif
              if (idx == 2'd3) begin
                bus.imem_wr    <= 1'b1;
                bus.imem_wdata <= {shreg, word[23:0]};
                bus.imem_addr  <= addr_cnt;
                addr_cnt       <= addr_cnt + ADDR_WIDTH'(4);
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          S_BRK:
            if (rx_sync) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed 8N1 stimulus at BAUD_DIV=16 with a write monitor and inline checks.
module tb_uart_imem_loader;
  logic clk = 1'b0, rst = 1'b1, load_imem = 1'b0, rxd = 1'b1;
  logic loading, frame_err;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif
  int total = 0, bad = 0;
  int wr_cycles = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];

  uart_imem_loader_if #(.ADDR_WIDTH(16)) bus ();

  uart_imem_loader #(.BAUD_DIV(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(rst), .load_imem(load_imem), .uart_rxd(rxd),
    .bus(bus), .loading(loading), .frame_err(frame_err)
`ifdef UART_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.imem_wr === 1'b1) begin
      wr_cycles++;
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic restart_load();
    load_imem = 1'b0;
    repeat (3) @(negedge clk);
    load_imem = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    total++; if (bus.imem_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", bus.imem_wr); end
    total++; if (bus.imem_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", bus.imem_addr); end
    total++; if (bus.imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=00000000", bus.imem_wdata); end
    total++; if ({loading, frame_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {loading, frame_err}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int n0;
    restart_load();
    n0 = wa.size();
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (wa.size() !== n0 + 1) begin bad++; $display("FAIL single_count got=%0d exp=%0d", wa.size() - n0, 1); end
    else begin
      total++; if (wa[n0] !== 16'h0000) begin bad++; $display("FAIL single_addr got=%h exp=0000", wa[n0]); end
      total++; if (wd[n0] !== 32'h00000013) begin bad++; $display("FAIL single_data got=%h exp=00000013", wd[n0]); end
    end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL single_ferr got=%b exp=0", frame_err); end
    total++; if (bus.imem_wdata !== 32'h00000013) begin bad++; $display("FAIL single_hold got=%h exp=00000013", bus.imem_wdata); end
  endtask

  task automatic test_two_words();
    int n0, c0;
    logic [7:0] img [8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    restart_load();
    n0 = wa.size();
    c0 = wr_cycles;
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b1);
    repeat (20) @(negedge clk);
    total++; if (wr_cycles - c0 !== 2) begin bad++; $display("FAIL two_pulse_cycles got=%0d exp=2", wr_cycles - c0); end
    total++; if (wa.size() !== n0 + 2) begin bad++; $display("FAIL two_count got=%0d exp=2", wa.size() - n0); end
    else begin
      total++; if ({wa[n0], wd[n0]} !== {16'h0000, 32'h00100093}) begin bad++; $display("FAIL two_w0 got=%h/%h exp=0000/00100093", wa[n0], wd[n0]); end
      total++; if ({wa[n0+1], wd[n0+1]} !== {16'h0004, 32'h00200113}) begin bad++; $display("FAIL two_w1 got=%h/%h exp=0004/00200113", wa[n0+1], wd[n0+1]); end
    end
  endtask

  task automatic test_frame_error();
    int n0;
    restart_load();
    n0 = wa.size();
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_set got=%b exp=1", frame_err); end
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (wa.size() !== n0 + 1) begin bad++; $display("FAIL frame_count got=%0d exp=1", wa.size() - n0); end
    else begin
      total++; if ({wa[n0], wd[n0]} !== {16'h0000, 32'h44332211}) begin bad++; $display("FAIL frame_word got=%h/%h exp=0000/44332211", wa[n0], wd[n0]); end
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_sticky got=%b exp=1", frame_err); end
    restart_load();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_glitch();
    int n0;
    restart_load();
    n0 = wa.size();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (wa.size() !== n0) begin bad++; $display("FAIL glitch_write got=%0d exp=0", wa.size() - n0); end
    total++; if ({loading, frame_err} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b exp=00", {loading, frame_err}); end
  endtask

  task automatic test_abort();
    int n0;
    restart_load();
    n0 = wa.size();
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (loading !== 1'b1) begin bad++; $display("FAIL abort_loading_hi got=%b exp=1", loading); end
    load_imem = 1'b0;
    @(negedge clk);
    total++; if (loading !== 1'b0) begin bad++; $display("FAIL abort_loading_lo got=%b exp=0", loading); end
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    load_imem = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (wa.size() !== n0 + 1) begin bad++; $display("FAIL abort_count got=%0d exp=1", wa.size() - n0); end
    else begin
      total++; if ({wa[n0], wd[n0]} !== {16'h0000, 32'hDDCCBBAA}) begin bad++; $display("FAIL abort_word got=%h/%h exp=0000/ddccbbaa", wa[n0], wd[n0]); end
    end
  endtask

  task automatic test_checksum();
    int n0;
    restart_load();
    n0 = wa.size();
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (wa.size() !== n0 + 1) begin bad++; $display("FAIL cks_count got=%0d exp=1", wa.size() - n0); end
    else begin
      total++; if (wd[n0] !== 32'hFF030201) begin bad++; $display("FAIL cks_word got=%h exp=ff030201", wd[n0]); end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    total++; if (checksum !== 8'h05) begin bad++; $display("FAIL cks_value got=%h exp=05", checksum); end
`endif
  endtask

  task automatic test_reset_mid_byte();
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({bus.imem_wr, bus.imem_addr, bus.imem_wdata} !== 49'h0) begin bad++; $display("FAIL midrst_bus got=%b/%h/%h exp=0/0000/00000000", bus.imem_wr, bus.imem_addr, bus.imem_wdata); end
    total++; if ({loading, frame_err} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b exp=00", {loading, frame_err}); end
`ifdef UART_LOADER_CHECKSUM_EN
    total++; if (checksum !== 8'h00) begin bad++; $display("FAIL midrst_cks got=%h exp=00", checksum); end
`endif
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_frame_error();
    test_glitch();
    test_abort();
    test_checksum();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
